// File: rtl/riscv_su_stacker.sv
// Stacking-unit context datapath: pushes/pops a NUM_REGS-word register frame to/from memory
// under control of the arbiter status. Optional depth check: RISCV_SU_DEPTH_CHECK_EN.
module riscv_su_stacker #(
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned MAX_DEPTH    = 4,
  parameter int unsigned SU_FSM_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic [SU_FSM_WIDTH-1:0]        i_fsm_status,
  input  logic                           i_sp_load,
  input  logic [ADDR_WIDTH-1:0]          i_sp,
  output logic [ADDR_WIDTH-1:0]          o_sp,
  output logic [$clog2(MAX_DEPTH+1)-1:0] o_depth,
  output logic [$clog2(NUM_REGS)-1:0]    o_rf_raddr,
  input  logic [DATA_WIDTH-1:0]          i_rf_rdata,
  output logic                           o_rf_we,
  output logic [$clog2(NUM_REGS)-1:0]    o_rf_waddr,
  output logic [DATA_WIDTH-1:0]          o_rf_wdata,
  output logic                           o_mem_req,
  output logic                           o_mem_we,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  output logic [DATA_WIDTH-1:0]          o_mem_wdata,
  input  logic                           i_mem_gnt,
  input  logic                           i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]          i_mem_rdata,
  output logic                           o_all_in_stacked,
  output logic                           o_all_unstacked,
  output logic                           o_overflow
);

  localparam int unsigned IdxW   = $clog2(NUM_REGS);
  localparam int unsigned DepthW = $clog2(MAX_DEPTH + 1);

  localparam logic [IdxW-1:0]       LastIdx    = IdxW'(NUM_REGS - 1);
  localparam logic [DepthW-1:0]     MaxDepth   = DepthW'(MAX_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] Bytes      = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] FrameBytes = ADDR_WIDTH'(NUM_REGS * (DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    StIdle,
    StPush,
    StPopReq,
    StPopWait,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   sp_q, sp_d;
  logic [DepthW-1:0]       depth_q, depth_d;
  logic                    pop_q, pop_d;
  logic                    stacked_q, stacked_d;
  logic                    unstacked_q, unstacked_d;

  logic st_stack, st_unstack, st_abort;

`ifdef RISCV_SU_DEPTH_CHECK_EN
  logic overflow_q;
  logic ovf_set;
`endif

  assign st_stack   = (i_fsm_status == SU_FSM_WIDTH'(1));
  assign st_unstack = (i_fsm_status == SU_FSM_WIDTH'(4));
  assign st_abort   = (i_fsm_status >= SU_FSM_WIDTH'(5));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      sp_q        <= '0;
      depth_q     <= '0;
      pop_q       <= 1'b0;
      stacked_q   <= 1'b0;
      unstacked_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sp_q        <= sp_d;
      depth_q     <= depth_d;
      pop_q       <= pop_d;
      stacked_q   <= stacked_d;
      unstacked_q <= unstacked_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sp_d        = sp_q;
    depth_d     = depth_q;
    pop_d       = pop_q;
    stacked_d   = 1'b0;
    unstacked_d = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_rf_we     = 1'b0;
`ifdef RISCV_SU_DEPTH_CHECK_EN
    ovf_set     = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_sp_load && (depth_q == '0)) begin
          sp_d = i_sp;
        end
        if (st_stack) begin
`ifdef RISCV_SU_DEPTH_CHECK_EN
          // A full stack refuses the push; the arbiter is expected to abort.
          if (depth_q == MaxDepth) begin
            ovf_set = 1'b1;
          end else begin
            state_d = StPush;
            idx_d   = '0;
            pop_d   = 1'b0;
          end
`else
          state_d = StPush;
          idx_d   = '0;
          pop_d   = 1'b0;
`endif
        end else if (st_unstack) begin
          idx_d = '0;
          pop_d = 1'b1;
          if (depth_q != '0) begin
            state_d = StPopReq;
          end else begin
            unstacked_d = 1'b1;
            state_d     = StDone;
          end
        end
      end

      StPush: begin
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b1;
        o_mem_addr = sp_q - ((ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1)) * Bytes);
        if (i_mem_gnt) begin
          if (idx_q == LastIdx) begin
            idx_d     = '0;
            sp_d      = sp_q - FrameBytes;
            depth_d   = (depth_q == MaxDepth) ? depth_q : depth_q + DepthW'(1);
            stacked_d = 1'b1;
            state_d   = StDone;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end

      StPopReq: begin
        o_mem_req  = 1'b1;
        o_mem_addr = sp_q + (ADDR_WIDTH'(LastIdx - idx_q) * Bytes);
        if (i_mem_gnt) begin
          state_d = StPopWait;
        end
      end

      StPopWait: begin
        if (i_mem_rvalid) begin
          o_rf_we = 1'b1;
          if (idx_q != LastIdx) begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StPopReq;
          end else begin
            idx_d       = '0;
            sp_d        = sp_q + FrameBytes;
            depth_d     = (depth_q == '0) ? depth_q : depth_q - DepthW'(1);
            unstacked_d = 1'b1;
            state_d     = StDone;
          end
        end
      end

      StDone: begin
        // Wait for the arbiter to leave the triggering status so one request yields one frame.
        if ((pop_q && !st_unstack) || (!pop_q && !st_stack)) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort withdraws the request at once; sp and depth only commit on completion.
    if (st_abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      idx_d       = '0;
      sp_d        = sp_q;
      depth_d     = depth_q;
      stacked_d   = 1'b0;
      unstacked_d = 1'b0;
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_rf_we     = 1'b0;
    end
  end

`ifdef RISCV_SU_DEPTH_CHECK_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      overflow_q <= 1'b0;
    end else if (ovf_set) begin
      overflow_q <= 1'b1;
    end
  end
  assign o_overflow = overflow_q;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_sp             = sp_q;
  assign o_depth          = depth_q;
  assign o_rf_raddr       = idx_q;
  assign o_rf_waddr       = idx_q;
  assign o_rf_wdata       = i_mem_rdata;
  assign o_mem_wdata      = i_rf_rdata;
  assign o_all_in_stacked = stacked_q;
  assign o_all_unstacked  = unstacked_q;

endmodule

// File: tb/tb_riscv_su_stacker.sv
// Randomized bench for riscv_su_stacker: memory/RF environment plus a frame-stack model.
module tb_riscv_su_stacker;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned NR = 16;
  localparam int unsigned MD = 2;
  localparam logic [63:0] FRAME = 64'd128;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [2:0]    fsm_status = 3'd0;
  logic          sp_load = 1'b0;
  logic [AW-1:0] sp_in = '0;
  logic [AW-1:0] sp_out;
  logic [1:0]    depth;
  logic [3:0]    rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          rf_we;
  logic [3:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          all_in_stacked, all_unstacked, overflow;

  logic [63:0] rf_base = '0;
  assign rf_rdata = rf_base + 64'(rf_raddr);

  always #5 clk = ~clk;

  riscv_su_stacker #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_REGS    (NR),
    .MAX_DEPTH   (MD),
    .SU_FSM_WIDTH(3)
  ) dut (
    .clk             (clk),
    .nreset          (nreset),
    .i_fsm_status    (fsm_status),
    .i_sp_load       (sp_load),
    .i_sp            (sp_in),
    .o_sp            (sp_out),
    .o_depth         (depth),
    .o_rf_raddr      (rf_raddr),
    .i_rf_rdata      (rf_rdata),
    .o_rf_we         (rf_we),
    .o_rf_waddr      (rf_waddr),
    .o_rf_wdata      (rf_wdata),
    .o_mem_req       (mem_req),
    .o_mem_we        (mem_we),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .i_mem_gnt       (mem_gnt),
    .i_mem_rvalid    (mem_rvalid),
    .i_mem_rdata     (mem_rdata),
    .o_all_in_stacked(all_in_stacked),
    .o_all_unstacked (all_unstacked),
    .o_overflow      (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Model: sp, depth and the rf base value of every frame pushed (latest at the back).
  logic [63:0] m_sp = '0;
  int          m_depth = 0;
  logic [63:0] fr_q[$];
  logic [63:0] mem[logic [63:0]];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_sp"}, sp_out, m_sp);
    check_eq({tag, "_depth"}, 64'(depth), 64'(m_depth));
  endtask

  task automatic do_push(input int max_stall, input logic [63:0] base_val);
    int n = 0;
    int cyc = 0;
    int stall;
    int req_cycles = 0;
    logic [63:0] top = m_sp;
    rf_base = base_val;
    fsm_status = 3'd1;
    stall = $urandom_range(0, max_stall);
    while (cyc < 1000) begin
      mem_gnt = (stall == 0);
      #1;
      if (all_in_stacked) break;
      if (mem_req) begin
        req_cycles++;
        if (n < int'(NR)) begin
          check_eq("push_we", 64'(mem_we), 64'd1);
          check_eq("push_addr", mem_addr, top - 64'((n + 1) * 8));
          check_eq("push_wdata", mem_wdata, base_val + 64'(n));
        end else begin
          check_eq("push_extra_req", 64'(n), 64'(NR - 1));
        end
        if (mem_gnt) begin
          mem[mem_addr] = mem_wdata;
          n++;
          stall = $urandom_range(0, max_stall);
        end else begin
          stall--;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_gnt = 1'b0;
    check_eq("push_pulse_seen", 64'(cyc < 1000), 64'd1);
    check_eq("push_words", 64'(n), 64'(NR));
    if (max_stall == 0) check_eq("push_latency", 64'(req_cycles), 64'(NR));
    m_sp = m_sp - FRAME;
    if (m_depth < int'(MD)) m_depth++;
    fr_q.push_back(base_val);
    check_state("push");
    @(negedge clk);
    #1;
    check_eq("push_pulse_len", 64'(all_in_stacked), 64'd0);
    check_eq("push_no_retrigger", 64'(mem_req), 64'd0);
    fsm_status = 3'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_pop(input int max_stall, input int max_rv);
    int n = 0;
    int cyc = 0;
    int stall;
    int rvd = 0;
    bit pend = 1'b0;
    bit empty;
    logic [63:0] paddr = '0;
    logic [63:0] base_val;
    logic [63:0] top = m_sp;
    empty = (m_depth == 0);
    base_val = empty ? 64'd0 : fr_q[$];
    fsm_status = 3'd4;
    stall = $urandom_range(0, max_stall);
    while (cyc < 2000) begin
      mem_gnt    = (stall == 0);
      mem_rvalid = pend && (rvd == 0);
      mem_rdata  = (pend && mem.exists(paddr)) ? mem[paddr] : 64'd0;
      #1;
      if (all_unstacked) break;
      if (mem_rvalid) begin
        check_eq("pop_rf_we", 64'(rf_we), 64'd1);
        check_eq("pop_rf_waddr", 64'(rf_waddr), 64'(n));
        check_eq("pop_rf_wdata", rf_wdata, base_val + 64'(n));
        n++;
        pend = 1'b0;
      end else begin
        check_eq("pop_idle_we", 64'(rf_we), 64'd0);
        if (pend) rvd--;
      end
      if (mem_req) begin
        check_eq("pop_one_outstanding", 64'(pend), 64'd0);
        check_eq("pop_we", 64'(mem_we), 64'd0);
        check_eq("pop_addr", mem_addr, top + 64'((int'(NR) - 1 - n) * 8));
        if (mem_gnt) begin
          pend  = 1'b1;
          paddr = mem_addr;
          rvd   = $urandom_range(0, max_rv);
          stall = $urandom_range(0, max_stall);
        end else begin
          stall--;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check_eq("pop_pulse_seen", 64'(cyc < 2000), 64'd1);
    check_eq("pop_words", 64'(n), empty ? 64'd0 : 64'(NR));
    if (!empty) begin
      m_sp = m_sp + FRAME;
      m_depth--;
      void'(fr_q.pop_back());
    end
    check_state("pop");
    @(negedge clk);
    #1;
    check_eq("pop_pulse_len", 64'(all_unstacked), 64'd0);
    fsm_status = 3'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic load_sp(input logic [63:0] v, input bool_ok);
    sp_load = 1'b1;
    sp_in   = v;
    @(negedge clk);
    sp_load = 1'b0;
    if (bool_ok) m_sp = v;
    #1;
    check_state("sp_load");
  endtask

  initial begin
    int n;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_req", 64'(mem_req), 64'd0);
    check_eq("rst_rf_we", 64'(rf_we), 64'd0);
    check_eq("rst_stacked", 64'(all_in_stacked), 64'd0);
    check_eq("rst_unstacked", 64'(all_unstacked), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_raddr", 64'(rf_raddr), 64'd0);
    check_state("rst");
    nreset = 1'b1;
    @(negedge clk);

    load_sp(64'h1000, 1'b1);
    do_push(0, 64'd0);
    load_sp(64'h5550, 1'b0);
    do_pop(0, 0);

    // Nested frames: preemption between two stacking requests.
    do_push(5, {$urandom, $urandom});
    fsm_status = 3'd2;
    @(negedge clk);
    fsm_status = 3'd3;
    @(negedge clk);
    @(negedge clk);
    do_push(5, {$urandom, $urandom});

`ifdef RISCV_SU_DEPTH_CHECK_EN
    fsm_status = 3'd1;
    mem_gnt    = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      check_eq("ovf_no_req", 64'(mem_req), 64'd0);
      check_eq("ovf_no_pulse", 64'(all_in_stacked), 64'd0);
    end
    check_eq("ovf_flag", 64'(overflow), 64'd1);
    mem_gnt    = 1'b0;
    fsm_status = 3'd5;
    @(negedge clk);
    fsm_status = 3'd0;
    @(negedge clk);
    #1;
    check_eq("ovf_sticky", 64'(overflow), 64'd1);
    check_state("ovf");
`else
    do_push(3, {$urandom, $urandom});
    check_eq("ovf_flag_off", 64'(overflow), 64'd0);
`endif

    while (m_depth > 0) do_pop(5, 3);
    do_pop(2, 2);
    load_sp(64'h1000, 1'b1);

    // Abort a push after seven words have been granted.
    fsm_status = 3'd1;
    mem_gnt    = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 7; c++) begin
      #1;
      if (mem_req) n++;
      @(negedge clk);
    end
    fsm_status = 3'd5;
    #1;
    check_eq("abort_req_drop", 64'(mem_req), 64'd0);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check_state("abort");
    check_eq("abort_no_pulse", 64'(all_in_stacked), 64'd0);
    fsm_status = 3'd0;
    @(negedge clk);
    do_push(3, {$urandom, $urandom});
    do_pop(3, 2);

    for (int r = 0; r < 6; r++) begin
      if ((m_depth < int'(MD)) && ((m_depth == 0) || ($urandom_range(0, 1) == 1)))
        do_push(4, {$urandom, $urandom});
      else
        do_pop(4, 3);
    end

    // Reset in the middle of a stalled push.
    fsm_status = 3'd1;
    mem_gnt    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("midrst_req_before", 64'(mem_req), 64'd1);
    nreset = 1'b0;
    #1;
    m_sp    = '0;
    m_depth = 0;
    fr_q.delete();
    check_eq("midrst_req", 64'(mem_req), 64'd0);
    check_eq("midrst_we", 64'(mem_we), 64'd0);
    check_eq("midrst_overflow", 64'(overflow), 64'd0);
    check_state("midrst");
    fsm_status = 3'd0;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
